// File: rtl/acumulador_4bits.sv
// Accumulator control stage around an external 4-bit adder/subtractor: 3-state FSM, flags, done pulse, op counter.
// Define SATURACAO_EN to clamp results on overflow (add) or borrow (subtract) instead of wrapping modulo 16.
module acumulador_4bits #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       DADO,
  input  logic             OP,
  input  logic             INICIO,
  input  logic             LIMPA,
  input  logic [4:0]       SOMA,
  output logic [3:0]       ACC_A,
  output logic [3:0]       ACC_B,
  output logic             ACC_C0,
  output logic [3:0]       ACUM,
  output logic             CARRY,
  output logic             ZERO,
  output logic             PRONTO,
  output logic             FIM,
  output logic [CNT_W-1:0] CONT_OPS
);

  typedef enum logic [1:0] {
    S_OCIOSO = 2'd0,
    S_CALC   = 2'd1,
    S_FIM    = 2'd2
  } estado_t;

  estado_t    state;
  estado_t    state_next;
  logic [3:0] dado_reg;
  logic       op_reg;
  logic [3:0] resultado;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_OCIOSO;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_OCIOSO: if (!LIMPA && INICIO) state_next = S_CALC;
      S_CALC:   state_next = S_FIM;
      S_FIM:    state_next = S_OCIOSO;
      default:  state_next = S_OCIOSO;
    endcase
  end

  always_comb begin
    PRONTO = (state == S_OCIOSO);
    FIM    = (state == S_FIM);
  end

  // SOMA[4] means carry on add and "no borrow" on subtract.
  always_comb begin
    resultado = SOMA[3:0];
`ifdef SATURACAO_EN
    if (!op_reg && SOMA[4])
      resultado = 4'hF;
    else if (op_reg && !SOMA[4])
      resultado = 4'h0;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ACUM     <= 4'h0;
      CARRY    <= 1'b0;
      ZERO     <= 1'b1;
      dado_reg <= 4'h0;
      op_reg   <= 1'b0;
      CONT_OPS <= '0;
    end else begin
      case (state)
        S_OCIOSO: begin
          if (LIMPA) begin
            ACUM  <= 4'h0;
            CARRY <= 1'b0;
            ZERO  <= 1'b1;
          end else if (INICIO) begin
            dado_reg <= DADO;
            op_reg   <= OP;
          end
        end
        S_CALC: begin
          ACUM  <= resultado;
          CARRY <= SOMA[4];
          ZERO  <= (resultado == 4'h0);
          if (CONT_OPS != {CNT_W{1'b1}})
            CONT_OPS <= CONT_OPS + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ACC_A  = ACUM;
  assign ACC_B  = dado_reg;
  assign ACC_C0 = op_reg;

endmodule

// File: tb/tb_acumulador_4bits.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=2) share stimulus; each has its own adder model.
module tb_acumulador_4bits;

  logic       clk;
  logic       rst;
  logic [3:0] dado;
  logic       op;
  logic       inicio;
  logic       limpa;

  logic [4:0] soma_a,   soma_b;
  logic [3:0] acc_a_a,  acc_a_b;
  logic [3:0] acc_b_a,  acc_b_b;
  logic       acc_c0_a, acc_c0_b;
  logic [3:0] acum_a,   acum_b;
  logic       carry_a,  carry_b;
  logic       zero_a,   zero_b;
  logic       pronto_a, pronto_b;
  logic       fim_a,    fim_b;
  logic [7:0] cont_a;
  logic [1:0] cont_b;

  acumulador_4bits #(.CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .DADO(dado), .OP(op), .INICIO(inicio), .LIMPA(limpa),
    .SOMA(soma_a), .ACC_A(acc_a_a), .ACC_B(acc_b_a), .ACC_C0(acc_c0_a),
    .ACUM(acum_a), .CARRY(carry_a), .ZERO(zero_a), .PRONTO(pronto_a),
    .FIM(fim_a), .CONT_OPS(cont_a)
  );

  acumulador_4bits #(.CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .DADO(dado), .OP(op), .INICIO(inicio), .LIMPA(limpa),
    .SOMA(soma_b), .ACC_A(acc_a_b), .ACC_B(acc_b_b), .ACC_C0(acc_c0_b),
    .ACUM(acum_b), .CARRY(carry_b), .ZERO(zero_b), .PRONTO(pronto_b),
    .FIM(fim_b), .CONT_OPS(cont_b)
  );

  // Adder model: subtract is A + ~B + 1, bit 4 set means no borrow.
  assign soma_a = acc_c0_a ? ({1'b0, acc_a_a} + {1'b0, ~acc_b_a} + 5'd1) : ({1'b0, acc_a_a} + {1'b0, acc_b_a});
  assign soma_b = acc_c0_b ? ({1'b0, acc_a_b} + {1'b0, ~acc_b_b} + 5'd1) : ({1'b0, acc_a_b} + {1'b0, acc_b_b});

  typedef struct {
    int acum;
    int carry;
    int zero;
    int cnt8;
    int cnt2;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ops_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every FIM pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (fim_a != fim_b) chk("fim_agree", fim_b, fim_a);
      if (fim_a) begin
        if (q.size() == 0) begin
          chk("unexpected_fim", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("fim_timing", cyc, e.cyc);
          chk("acum", acum_a, e.acum);
          chk("carry", carry_a, e.carry);
          chk("zero", zero_a, e.zero);
          chk("cont_ops8", cont_a, e.cnt8);
          chk("cont_ops2", cont_b, e.cnt2);
          chk("acum_dut2", acum_b, e.acum);
          chk("pronto_in_fim", pronto_a, 0);
        end
      end
    end
  end

  // Called at a negedge in idle; returns at the negedge after PRONTO comes back.
  task automatic do_op(input logic [3:0] d, input logic o, input int ea, input int ec, input int ez, input int hold);
    exp_t e;
    dado   = d;
    op     = o;
    inicio = 1'b1;
    ops_n++;
    e.acum  = ea;
    e.carry = ec;
    e.zero  = ez;
    e.cnt8  = (ops_n > 255) ? 255 : ops_n;
    e.cnt2  = (ops_n > 3) ? 3 : ops_n;
    e.cyc   = cyc + 2;
    q.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    inicio = 1'b0;
    dado   = ~d;
    op     = ~o;
    repeat (4 - hold) @(negedge clk);
    chk("pronto_after_op", pronto_a, 1);
  endtask

  task automatic do_limpa(input logic with_inicio);
    limpa  = 1'b1;
    inicio = with_inicio;
    dado   = 4'h9;
    @(posedge clk);
    #1;
    limpa  = 1'b0;
    inicio = 1'b0;
    @(negedge clk);
    chk("limpa_acum", acum_a, 0);
    chk("limpa_carry", carry_a, 0);
    chk("limpa_zero", zero_a, 1);
    chk("limpa_pronto", pronto_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dado = 4'h0; op = 1'b0; inicio = 1'b0; limpa = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acum", acum_a, 0);
    chk("rst_zero", zero_a, 1);
    chk("rst_carry", carry_a, 0);
    chk("rst_pronto", pronto_a, 1);
    chk("rst_fim", fim_a, 0);
    chk("rst_cont", cont_a, 0);
    chk("rst_acc_b", acc_b_a, 0);
    chk("rst_acc_c0", acc_c0_a, 0);

    do_op(4'd5, 1'b0, 5, 0, 0, 1);
    do_op(4'd3, 1'b0, 8, 0, 0, 1);
`ifdef SATURACAO_EN
    do_op(4'd9, 1'b0, 15, 1, 0, 1);
`else
    do_op(4'd9, 1'b0, 1, 1, 0, 1);
`endif
    do_limpa(1'b0);
    chk("limpa_keeps_cont", cont_a, 3);
    do_op(4'd1, 1'b0, 1, 0, 0, 1);
`ifdef SATURACAO_EN
    do_op(4'd2, 1'b1, 0, 0, 1, 1);
`else
    do_op(4'd2, 1'b1, 15, 0, 0, 1);
`endif
    do_limpa(1'b0);
    do_op(4'd5, 1'b0, 5, 0, 0, 1);
    do_op(4'd5, 1'b1, 0, 1, 1, 1);
    do_op(4'd6, 1'b0, 6, 0, 0, 1);

    // LIMPA beats INICIO: no CALC, so no FIM may follow.
    do_limpa(1'b1);
    repeat (3) @(negedge clk);
    chk("limpa_inicio_pronto", pronto_a, 1);
    chk("limpa_inicio_no_op", cont_a, 8);

    // INICIO held through CALC and FIM: one operation only.
    do_op(4'd4, 1'b0, 4, 0, 0, 3);
    repeat (4) @(negedge clk);
    chk("held_inicio_cont", cont_a, 9);
    chk("held_inicio_queue", q.size(), 0);

    // Reset in CALC aborts the operation.
    dado = 4'd7; op = 1'b1; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_acum", acum_a, 0);
    chk("arst_carry", carry_a, 0);
    chk("arst_zero", zero_a, 1);
    chk("arst_pronto", pronto_a, 1);
    chk("arst_fim", fim_a, 0);
    chk("arst_cont8", cont_a, 0);
    chk("arst_cont2", cont_b, 0);
    chk("arst_acc_b", acc_b_a, 0);
    chk("arst_acc_c0", acc_c0_a, 0);
    ops_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_fim_queue", q.size(), 0);

    // Five ops: CNT_W=2 counter stops at 3.
    for (int i = 1; i <= 5; i++) do_op(4'd1, 1'b0, i, 0, 0, 1);
    chk("sat_cont2", cont_b, 3);
    chk("sat_cont8", cont_a, 5);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
